// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10-15 are not valid BCD and show a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; default covers the invalid BCD range.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_7seg_mux.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Digits are latched into shadow registers on load, scanned one per refresh
// slot, and driven out through registered active-low seg/dp/an pins.
module display_7seg_mux
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned BLINK_SLOTS = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] dig3,
  input  logic [3:0] dig2,
  input  logic [3:0] dig1,
  input  logic [3:0] dig0,
  input  logic [3:0] dp_mask,
  input  logic       lzb_en,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned PresW  = $clog2(REFRESH_DIV);
  localparam int unsigned BlinkW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

  localparam logic [PresW-1:0]  PresMax  = PresW'(REFRESH_DIV - 1);
  localparam logic [PresW-1:0]  DeadVal  = PresW'(DEAD_CYCLES);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_SLOTS - 1);

  // Shadow copies of the digit inputs; the scan only ever reads these.
  logic [NUM_DIGITS-1:0][3:0] digits_q;
  logic [NUM_DIGITS-1:0]      mask_q;

  logic [PresW-1:0]  presc_q, presc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic              wrap;

  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] zero_vec;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  cur_blank;
  logic [6:0]            dec_seg;

  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] an_q, an_d;

  // Capture new digits and decimal points on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      mask_q   <= '0;
    end else if (load) begin
      digits_q <= {dig3, dig2, dig1, dig0};
      mask_q   <= dp_mask;
    end
  end

  // Slot timing: prescaler wrap advances the scan and the blink counter.
  always_comb begin
    wrap        = (presc_q == PresMax);
    presc_d     = presc_q + PresW'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (wrap) begin
      presc_d = '0;
      idx_d   = idx_q + IdxW'(1);
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  // Leading-zero blanking: a digit blanks only if it and every digit above it is zero.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_vec[i] = (digits_q[i] == 4'd0);
    end
    blank_vec[3] = zero_vec[3];
    blank_vec[2] = zero_vec[3] & zero_vec[2];
    blank_vec[1] = zero_vec[3] & zero_vec[2] & zero_vec[1];
    blank_vec[0] = 1'b0;
  end

  assign cur_digit = digits_q[idx_q];
  assign cur_dp    = mask_q[idx_q];
  assign cur_blank = lzb_en & blank_vec[idx_q];

  bcd_to_7seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  // Next pin values; anode is held off during dead time and the blink-off phase.
  always_comb begin
    seg_d = cur_blank ? SEG_BLANK : dec_seg;
    dp_d  = ~cur_dp;
    an_d  = 4'hF;
    if ((presc_q >= DeadVal) && !(blink_en && blink_ph_q)) begin
      an_d[idx_q] = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: doc/display_7seg_mux.md
Name: display_7seg_mux

Overview:
- Time-multiplexed driver for a 4-digit common-anode seven-segment display.
- Consumes the BCD digit pairs (tens/units) produced by the binary-to-BCD converter stage.
- Latches the digits on a load strobe, scans one digit per refresh slot, and drives active-low segment and anode pins.
- Supports leading-zero blanking, whole-display blink, per-digit decimal points, and anti-ghosting dead time.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- DEAD_CYCLES, 2: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- BLINK_SLOTS, 256: number of digit slots per blink half-period; legal range ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- load  in  1  capture dig3..dig0 and dp_mask into shadow registers.
- dig3  in  4  BCD, most significant digit (e.g. minutes tens).
- dig2  in  4  BCD.
- dig1  in  4  BCD.
- dig0  in  4  BCD, least significant digit.
- dp_mask  in  4  decimal point on for digit i when bit i = 1.
- lzb_en  in  1  leading-zero blanking enable (live, not latched).
- blink_en  in  1  blink enable (live, not latched).
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  anode enables, active-low; bit i selects digit i.

Behaviour:
- One clock and a synchronous active-high reset, as already decided.
- Reset values:
  - seg = 7'h7F, dp = 1, an = 4'hF (display fully dark).
  - Shadow digits = 0, shadow dp_mask = 0.
  - Prescaler = 0, scan index = 0, blink counter = 0, blink phase = 0.
- Shadow load: when load = 1 at a clock edge, the shadow registers take dig3..0 and dp_mask. The display only ever reads the shadow registers, so there is no tearing mid-scan. Holding load high continuously gives transparent behaviour.
- Prescaler: counts 0 up to REFRESH_DIV-1, then wraps to 0.
  - On wrap, the scan index advances 0→1→2→3→0.
  - Also on wrap, the blink counter increments; when it reaches BLINK_SLOTS-1 it clears and blink phase toggles.
- Digit selection:
  - Digit i is the current scan index.
  - Its value comes from shadow[i]; its decimal point is shadow dp_mask[i].
- Leading-zero blanking (lzb_en = 1):
  - Digit 3 is blank if it is 0.
  - Digit 2 is blank if digits 3 and 2 are both 0.
  - Digit 1 is blank if digits 3, 2 and 1 are all 0.
  - Digit 0 is never blanked.
  - Blanking forces seg to 7'h7F; dp is unaffected.
- Decode, active-low, hex values:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - Values 10–15 (invalid BCD) display a dash, 3F.
- Anodes: an[i] = 0 only when all of the following hold; otherwise an = 4'hF:
  - the scan index is i,
  - prescaler ≥ DEAD_CYCLES,
  - NOT (blink_en AND blink phase = 1).
- Output registration and latency:
  - seg, dp and an are registered, so the pins follow the internal state with exactly 1 cycle of latency.
  - A load reaches the pins within at most one full slot plus 1 cycle.
- Mid-operation changes:
  - lzb_en and blink_en toggles take effect on the next output register update.
  - Deasserting blink_en does not reset the blink counter or phase.
- Simultaneous events: load and a slot wrap on the same edge are legal. The next slot uses the new shadow values.
- Reset mid-scan: everything returns to the reset values on the next edge, and the display is dark on the following cycle.

Decomposition:
- Shared package display_pkg holds:
  - the segment encoding constants SEG_0..SEG_9, SEG_DASH = 7'h3F and SEG_BLANK = 7'h7F;
  - the NUM_DIGITS = 4 constant.
- One combinational sub-module, bcd_to_7seg: 4-bit BCD in, 7-bit active-low segments out, decoding invalid codes to a dash.
- Prescaler, scan counter, blink logic, blanking logic and output registers stay in the top module.

Test Plan (REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_SLOTS=2):
- Reset → seg=7F, an=F, dp=1. Then load digits 1,2,3,4 with dp_mask=0 → per slot, an=E with seg=19; an=D with seg=30; an=B with seg=24; an=7 with seg=79. Each slot shows 1 dark cycle then 3 active cycles, with a 1-cycle output lag.
- lzb_en=1, load 0,0,0,7 → an=D/B/7 slots show seg=7F; the an=E slot shows seg=78. Then load 0,0,0,0 → the digit-0 slot shows seg=40.
- Load digit2 = 4'hC with dp_mask=4'b0100 → the an=B slot shows seg=3F and dp=0; all other slots show dp=1.
- blink_en=1 → an stays F for 2 full slots, is active for 2 slots, and the pattern repeats. Deassert blink_en mid-dark → an becomes active 1 cycle later, once past the dead cycles.
- Change dig inputs without load → no change on seg. Pulse load coincident with a slot wrap → the new value appears in that slot.
- Assert rst during the an=B slot → seg=7F and an=F on the next cycle; scanning restarts at digit 0 and the shadow values are 0.
